dot_writeback: RTL and testbench

- Write-side counterpart of the dot-product fetch path.
- Captures the full 12x32 result vector produced by the dot stage when its valid rises.
- Serialises the vector into 32 RAM words, one per output channel, each holding 12 elements. The words go to the next layer's feature RAM.
- Sits between the dot stage output and the feature-map RAM write port; the layer sequencer drives it with the same level-style load used upstream.

---
 rtl/dot_writeback_pkg.sv | 15 +
 rtl/dot_writeback_word_sel.sv | 34 +++
 rtl/dot_writeback.sv | 106 ++++++++++
 tb/tb_dot_writeback.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_writeback_pkg.sv
// Shared layer constants and writeback FSM state encoding.
package dot_writeback_pkg;

    localparam int unsigned DW_DATA_LEN  = 16;
    localparam int unsigned DW_CHANNELS  = 32;
    localparam int unsigned DW_POSITIONS = 12;
    localparam int unsigned DW_ADDR_W    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dot_writeback_word_sel.sv
// Picks one channel word out of the result vector; optional ReLU clamp
// on each element when DOT_WRITEBACK_RELU_EN is defined.
module dot_writeback_word_sel #(
    parameter int unsigned DATA_LEN  = 16,
    parameter int unsigned CHANNELS  = 32,
    parameter int unsigned POSITIONS = 12,
    parameter int unsigned CNT_W     = 5
) (
    input  logic [CHANNELS*POSITIONS*DATA_LEN-1:0] i_vec,
    input  logic [CNT_W-1:0]                       i_idx,
    output logic [POSITIONS*DATA_LEN-1:0]          o_word_c
);

    localparam int unsigned WORD_W = POSITIONS * DATA_LEN;

    logic [WORD_W-1:0] w_raw;

    assign w_raw = i_vec[WORD_W*int'(i_idx) +: WORD_W];

`ifdef DOT_WRITEBACK_RELU_EN
    // Negative elements are written as zero; non-negative pass unchanged.
    always_comb begin
        o_word_c = w_raw;
        for (int j = 0; j < int'(POSITIONS); j++) begin
            if (w_raw[j*int'(DATA_LEN) + int'(DATA_LEN) - 1]) begin
                o_word_c[j*int'(DATA_LEN) +: DATA_LEN] = '0;
            end
        end
    end
`else
    assign o_word_c = w_raw;
`endif

endmodule

// File: rtl/dot_writeback.sv
// Captures the dot-stage result vector and streams it to the feature RAM,
// one channel word per accepted write. Optional DOT_WRITEBACK_RELU_EN clamp.
module dot_writeback
    import dot_writeback_pkg::*;
#(
    parameter int unsigned DATA_LEN  = DW_DATA_LEN,
    parameter int unsigned CHANNELS  = DW_CHANNELS,
    parameter int unsigned POSITIONS = DW_POSITIONS,
    parameter int unsigned ADDR_W    = DW_ADDR_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load,
    input  logic                                   in_valid,
    input  logic [ADDR_W-1:0]                      base,
    input  logic [CHANNELS*POSITIONS*DATA_LEN-1:0] d,
    input  logic                                   wr_ready,
    output logic                                   we,
    output logic [ADDR_W-1:0]                      addr,
    output logic [POSITIONS*DATA_LEN-1:0]          wdata,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned VEC_W  = CHANNELS * POSITIONS * DATA_LEN;
    localparam int unsigned WORD_W = POSITIONS * DATA_LEN;
    localparam int unsigned CNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHANNELS - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [VEC_W-1:0]  r_buf;

    logic [VEC_W-1:0]  w_sel_vec;
    logic [CNT_W-1:0]  w_sel_idx;
    logic [WORD_W-1:0] w_word;

    // Word 0 comes straight from d on the capture edge; later words from the buffer.
    assign w_sel_vec = (r_state == ST_WRITE) ? r_buf : d;
    assign w_sel_idx = (r_state == ST_WRITE) ? (r_cnt + CNT_W'(1)) : '0;

    dot_writeback_word_sel #(
        .DATA_LEN  (DATA_LEN),
        .CHANNELS  (CHANNELS),
        .POSITIONS (POSITIONS),
        .CNT_W     (CNT_W)
    ) u_word_sel (
        .i_vec    (w_sel_vec),
        .i_idx    (w_sel_idx),
        .o_word_c (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!load) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            we      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_buf   <= d;
                        r_cnt   <= '0;
                        addr    <= base;
                        wdata   <= w_word;
                        we      <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (r_cnt == LAST_CNT) begin
                            we      <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            addr  <= addr + ADDR_W'(1);
                            wdata <= w_word;
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_writeback.sv
// Self-checking bench for dot_writeback: scenario table plus randomized runs
// against an element-array model of the written words.
module tb_dot_writeback;
    import dot_writeback_pkg::*;

    localparam int unsigned DL     = DW_DATA_LEN;
    localparam int unsigned CH     = DW_CHANNELS;
    localparam int unsigned POS    = DW_POSITIONS;
    localparam int unsigned AW     = DW_ADDR_W;
    localparam int unsigned WORD_W = POS * DL;
    localparam int unsigned VEC_W  = CH * POS * DL;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct {
        logic [AW-1:0] base;
        int            pattern;     // 0: 16*i+j, 1: random, 2: random + ReLU probe
        int            stall_word;
        int            stall_len;
        int            abort_after; // -1: run to completion
        bit            revalid;
        int            exp_lat;     // cycles from capture edge to done
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              in_valid;
    logic [AW-1:0]     base;
    logic [VEC_W-1:0]  d;
    logic              wr_ready;
    logic              we;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] wdata;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;
    logic [DL-1:0] elem [CH][POS];

    always #5 clk = ~clk;

    dot_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .in_valid (in_valid),
        .base     (base),
        .d        (d),
        .wr_ready (wr_ready),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DL-1:0] exp_elem(input logic [DL-1:0] e);
`ifdef DOT_WRITEBACK_RELU_EN
        if ($signed(e) < 0) return '0;
`endif
        return e;
    endfunction

    function automatic word_t exp_word(input int k);
        word_t w = '0;
        if (k < 0 || k >= int'(CH)) return '0;
        for (int j = 0; j < int'(POS); j++) w[j*DL +: DL] = exp_elem(elem[k][j]);
        return w;
    endfunction

    function automatic logic [VEC_W-1:0] pack_elems();
        logic [VEC_W-1:0] v = '0;
        for (int i = 0; i < int'(CH); i++)
            for (int j = 0; j < int'(POS); j++)
                v[(int'(POS)*i + j)*DL +: DL] = elem[i][j];
        return v;
    endfunction

    task automatic run(input vec_t v);
        int k = 0;
        int lat = 1;
        int stall_n = 0;
        bit seen_done = 0;
        logic [VEC_W-1:0] dv;
        logic [DL-1:0] probe;
        for (int i = 0; i < int'(CH); i++)
            for (int j = 0; j < int'(POS); j++)
                elem[i][j] = (v.pattern == 0) ? DL'(16*i + j) : DL'($urandom);
        if (v.pattern == 2) begin
            elem[3][4] = 16'hFFF0;
            elem[3][5] = 16'h0007;
        end
        dv = pack_elems();
        load = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
        step();
        d = dv; base = v.base; load = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (lat < 200 && !seen_done) begin
            if (done) begin
                chk("done_busy", word_t'(busy), word_t'(0));
                chk("done_we", word_t'(we), word_t'(0));
                chk("write_count", word_t'(k), word_t'(CH));
                chk("done_latency", word_t'(lat), word_t'(v.exp_lat));
                seen_done = 1;
            end else begin
                chk("we", word_t'(we), word_t'(1));
                chk("busy", word_t'(busy), word_t'(1));
                chk("addr", word_t'(addr), word_t'((int'(v.base) + k) % (1 << AW)));
                chk("wdata", wdata, exp_word(k));
                if (v.pattern == 2 && k == 3) begin
`ifdef DOT_WRITEBACK_RELU_EN
                    probe = 16'h0000;
`else
                    probe = 16'hFFF0;
`endif
                    chk("relu_pos4", word_t'(wdata[4*DL +: DL]), word_t'(probe));
                    chk("relu_pos5", word_t'(wdata[5*DL +: DL]), word_t'(16'h0007));
                end
                if (k == v.abort_after) begin
                    load = 1'b0;
                    step();
                    chk("abort_we", word_t'(we), word_t'(0));
                    chk("abort_busy", word_t'(busy), word_t'(0));
                    chk("abort_done", word_t'(done), word_t'(0));
                    step();
                    chk("abort_we_hold", word_t'(we), word_t'(0));
                    return;
                end
                if (v.revalid && k == 5) begin
                    in_valid = 1'b1;
                    d = ~dv;
                end else begin
                    in_valid = 1'b0;
                end
                wr_ready = !(k == v.stall_word && stall_n < v.stall_len);
                if (!wr_ready) stall_n++;
                else k++;
                step();
                lat++;
            end
        end
        in_valid = 1'b0;
        wr_ready = 1'b1;
        if (!seen_done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
        end
        // done holds while load stays high, even if in_valid pulses again
        in_valid = 1'b1; d = ~dv;
        step();
        chk("done_hold", word_t'(done), word_t'(1));
        chk("done_hold_we", word_t'(we), word_t'(0));
        in_valid = 1'b0;
        step();
        chk("done_hold2", word_t'(done), word_t'(1));
        load = 1'b0;
        step();
        chk("done_clear", word_t'(done), word_t'(0));
        chk("idle_busy", word_t'(busy), word_t'(0));
    endtask

    vec_t tbl [7];
    vec_t rv;

    initial begin
        tbl[0] = '{base: 9'd40,  pattern: 0, stall_word: -1, stall_len: 0, abort_after: -1, revalid: 0, exp_lat: 33};
        tbl[1] = '{base: 9'd40,  pattern: 1, stall_word: 10, stall_len: 3, abort_after: -1, revalid: 0, exp_lat: 36};
        tbl[2] = '{base: 9'd500, pattern: 1, stall_word: -1, stall_len: 0, abort_after: -1, revalid: 0, exp_lat: 33};
        tbl[3] = '{base: 9'd100, pattern: 1, stall_word: -1, stall_len: 0, abort_after: 7,  revalid: 0, exp_lat: 0};
        tbl[4] = '{base: 9'd200, pattern: 1, stall_word: -1, stall_len: 0, abort_after: -1, revalid: 0, exp_lat: 33};
        tbl[5] = '{base: 9'd7,   pattern: 1, stall_word: -1, stall_len: 0, abort_after: -1, revalid: 1, exp_lat: 33};
        tbl[6] = '{base: 9'd300, pattern: 2, stall_word: 3,  stall_len: 1, abort_after: -1, revalid: 0, exp_lat: 34};

        rst = 1'b1; load = 1'b0; in_valid = 1'b0; base = '0; d = '0; wr_ready = 1'b1;
        step();
        step();
        chk("rst_we", word_t'(we), word_t'(0));
        chk("rst_addr", word_t'(addr), word_t'(0));
        chk("rst_wdata", wdata, word_t'(0));
        chk("rst_busy", word_t'(busy), word_t'(0));
        chk("rst_done", word_t'(done), word_t'(0));
        rst = 1'b0;
        step();

        // in_valid without load must not capture
        in_valid = 1'b1; d = '1;
        step();
        step();
        chk("noload_we", word_t'(we), word_t'(0));
        chk("noload_busy", word_t'(busy), word_t'(0));
        in_valid = 1'b0;

        for (int t = 0; t < 7; t++) run(tbl[t]);

        for (int r = 0; r < 8; r++) begin
            rv.base        = AW'($urandom);
            rv.pattern     = 1;
            rv.stall_word  = int'($urandom_range(0, CH - 1));
            rv.stall_len   = int'($urandom_range(0, 4));
            rv.abort_after = -1;
            rv.revalid     = 1'($urandom);
            rv.exp_lat     = int'(CH) + 1 + rv.stall_len;
            run(rv);
        end

        // asynchronous reset in the middle of a write burst
        load = 1'b1; in_valid = 1'b1; base = 9'd77; d = '1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_we", word_t'(we), word_t'(0));
        chk("arst_busy", word_t'(busy), word_t'(0));
        chk("arst_addr", word_t'(addr), word_t'(0));
        rst = 1'b0;
        load = 1'b0;
        step();
        chk("arst_idle_we", word_t'(we), word_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
